paddle_bank_ctrl: RTL and testbench

- Parametrised multi-paddle controller for the Pong game. It holds the vertical cell position of NUM_PADDLES paddles and moves them from buttons or from a built-in ball-tracking AI.
- Manual movement uses hold-to-repeat timing: one immediate step, an initial delay, then repeated steps.
- It also produces a registered per-pixel draw flag and paddle ID for the VGA mixer.

---
 rtl/paddle_bank_ctrl.sv | 169 ++++++++++++++++
 tb/tb_paddle_bank_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_bank_ctrl.sv
// Multi-paddle Pong controller: game FSM, per-paddle hold-to-repeat / AI movement and a draw flag.
// Positions update on the clock edge; the draw flag and id are one cycle behind i_H_count/i_V_count.
module paddle_bank_ctrl #(
    parameter int HMAX         = 800,
    parameter int VMAX         = 525,
    parameter int V_CELLS      = 30,
    parameter int PIXEL_SIZE   = 16,
    parameter int NUM_PADDLES  = 2,
    parameter int H_POS0       = 4,
    parameter int H_STEP       = 31,
    parameter int HALF_H       = 3,
    parameter int V_INIT       = 15,
    parameter int V_POS_MIN    = 4,
    parameter int V_POS_MAX    = 26,
    parameter int FIRST_DELAY  = 6250000,
    parameter int REPEAT_DELAY = 1250000,
    parameter int AI_DELAY     = 1500000,
    parameter int AI_DEADBAND  = 1
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Reset,
    input  logic [$clog2(HMAX)-1:0]                i_H_count,
    input  logic [$clog2(VMAX)-1:0]                i_V_count,
    input  logic [NUM_PADDLES-1:0]                 i_Up,
    input  logic [NUM_PADDLES-1:0]                 i_Down,
    input  logic [NUM_PADDLES-1:0]                 i_AI_En,
    input  logic [$clog2(V_CELLS)-1:0]             i_Ball_V_pos,
    input  logic                                   i_Ready,
    input  logic                                   i_Start,
    input  logic                                   i_Out,
    output logic [NUM_PADDLES*$clog2(V_CELLS)-1:0] o_V_pos,
    output logic                                   o_Draw_Paddle,
    output logic [1:0]                             o_Draw_Id,
    output logic [1:0]                             o_Game_State
);
    localparam int PW    = $clog2(V_CELLS);
    localparam int MAXD0 = (FIRST_DELAY > REPEAT_DELAY) ? FIRST_DELAY : REPEAT_DELAY;
    localparam int MAXD  = (MAXD0 > AI_DELAY) ? MAXD0 : AI_DELAY;
    localparam int CW    = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [1:0] {G_RESET = 2'd0, G_START = 2'd1, G_PLAY = 2'd2} game_t;
    typedef enum logic [1:0] {P_IDLE, P_HOLD, P_REPEAT, P_AI} pad_t;

    game_t game_state;
    logic  enter_start;
    logic [NUM_PADDLES-1:0] hit;
    logic [1:0] hit_id;

    // One cell up or down, refusing to leave the legal centre range.
    function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic up);
        if (up)
            return (int'(p) > V_POS_MIN) ? p - PW'(1) : p;
        else
            return (int'(p) < V_POS_MAX) ? p + PW'(1) : p;
    endfunction

    assign enter_start = ((game_state != G_RESET) && i_Out) ||
                         ((game_state == G_RESET) && i_Ready);

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            game_state <= G_RESET;
        else if (enter_start)
            game_state <= G_START;
        else if (game_state == G_START && i_Start)
            game_state <= G_PLAY;
    end

    assign o_Game_State = game_state;

    for (genvar k = 0; k < NUM_PADDLES; k++) begin : g_pad
        localparam int COL_LO = (H_POS0 + k * H_STEP) * PIXEL_SIZE;

        pad_t          st;
        logic [CW-1:0] cnt;
        logic          dir_up;
        logic [PW-1:0] pos;
        logic          req_up;
        logic          req_dn;

        assign req_up = i_Up[k] & ~i_Down[k];
        assign req_dn = i_Down[k] & ~i_Up[k];

        always_ff @(posedge i_Clk) begin
            if (i_Reset || enter_start) begin
                pos    <= PW'(V_INIT);
                st     <= P_IDLE;
                cnt    <= '0;
                dir_up <= 1'b0;
            end else if (game_state != G_PLAY) begin
                st  <= P_IDLE;
                cnt <= '0;
            end else if (i_AI_En[k]) begin
                if (st != P_AI) begin
                    st  <= P_AI;
                    cnt <= '0;
                end else if (cnt == CW'(AI_DELAY - 1)) begin
                    cnt <= '0;
                    if (int'(i_Ball_V_pos) > int'(pos) + AI_DEADBAND)
                        pos <= step_pos(pos, 1'b0);
                    else if (int'(i_Ball_V_pos) + AI_DEADBAND < int'(pos))
                        pos <= step_pos(pos, 1'b1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                case (st)
                    P_AI: begin
                        st  <= P_IDLE;
                        cnt <= '0;
                    end
                    P_IDLE: begin
                        if (req_up || req_dn) begin
                            pos    <= step_pos(pos, req_up);
                            dir_up <= req_up;
                            cnt    <= '0;
                            st     <= P_HOLD;
                        end
                    end
                    default: begin
                        if (!(req_up || req_dn)) begin
                            st  <= P_IDLE;
                            cnt <= '0;
                        end else if (req_up != dir_up) begin
                            // Reversal restarts the full hold-to-repeat sequence.
                            pos    <= step_pos(pos, req_up);
                            dir_up <= req_up;
                            cnt    <= '0;
                            st     <= P_HOLD;
                        end else if (st == P_HOLD && cnt == CW'(FIRST_DELAY - 1)) begin
                            pos <= step_pos(pos, dir_up);
                            cnt <= '0;
                            st  <= P_REPEAT;
                        end else if (st == P_REPEAT && cnt == CW'(REPEAT_DELAY - 1)) begin
                            pos <= step_pos(pos, dir_up);
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                endcase
            end
        end

        assign o_V_pos[k*PW +: PW] = pos;

        assign hit[k] = (int'(i_H_count) >= COL_LO) &&
                        (int'(i_H_count) <  COL_LO + PIXEL_SIZE) &&
                        (int'(i_V_count) >= (int'(pos) - HALF_H) * PIXEL_SIZE) &&
                        (int'(i_V_count) <  (int'(pos) + HALF_H + 1) * PIXEL_SIZE);
    end

    always_comb begin
        hit_id = '0;
        for (int i = NUM_PADDLES - 1; i >= 0; i--)
            if (hit[i]) hit_id = 2'(i);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset || game_state == G_RESET) begin
            o_Draw_Paddle <= 1'b0;
            o_Draw_Id     <= '0;
        end else begin
            o_Draw_Paddle <= |hit;
            o_Draw_Id     <= (|hit) ? hit_id : 2'd0;
        end
    end

endmodule

// File: tb/tb_paddle_bank_ctrl.sv
// Bench for paddle_bank_ctrl: directed test-plan sequences, then randomized traffic,
// all checked every cycle against a cycle-age based model of the game and paddles.
module tb_paddle_bank_ctrl;
    localparam int PS = 16;
    localparam int FD = 4;
    localparam int RD = 2;
    localparam int AD = 3;
    localparam int DB = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h, v;
    logic [1:0] up, dn, ai;
    logic [4:0] ball;
    logic       ready, start, out;
    logic [9:0] vpos;
    logic       draw;
    logic [1:0] id, gs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    paddle_bank_ctrl #(
        .PIXEL_SIZE(PS), .NUM_PADDLES(2), .FIRST_DELAY(FD),
        .REPEAT_DELAY(RD), .AI_DELAY(AD), .AI_DEADBAND(DB)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_H_count(h), .i_V_count(v),
        .i_Up(up), .i_Down(dn), .i_AI_En(ai), .i_Ball_V_pos(ball),
        .i_Ready(ready), .i_Start(start), .i_Out(out),
        .o_V_pos(vpos), .o_Draw_Paddle(draw), .o_Draw_Id(id), .o_Game_State(gs)
    );

    // Model state: game state, positions, and per-paddle "age" since press / AI entry.
    int m_gs;
    int m_pos[2];
    bit m_act[2];
    int m_dir[2];    // 1 = up, 2 = down
    int m_age[2];
    bit m_ai[2];
    int m_aiage[2];
    bit m_draw;
    int m_id;
    bit chk = 1'b0;

    function automatic int moved(input int p, input int dir);
        int n;
        n = (dir == 1) ? p - 1 : p + 1;
        return (n >= 4 && n <= 26) ? n : p;
    endfunction

    function automatic bit on_paddle(input int k, input int p, input int hh, input int vv);
        return (hh / PS == 4 + k * 31) && (vv / PS >= p - 3) && (vv / PS <= p + 3);
    endfunction

    always @(posedge clk) begin
        bit enter;
        int req;
        m_draw = 1'b0;
        m_id   = 0;
        if (!rst && m_gs != 0)
            for (int k = 1; k >= 0; k--)
                if (on_paddle(k, m_pos[k], int'(h), int'(v))) begin
                    m_draw = 1'b1;
                    m_id   = k;
                end
        enter = (m_gs != 0 && out) || (m_gs == 0 && ready);
        for (int k = 0; k < 2; k++) begin
            req = (up[k] && !dn[k]) ? 1 : (dn[k] && !up[k]) ? 2 : 0;
            if (rst || enter) begin
                m_pos[k] = 15; m_act[k] = 1'b0; m_ai[k] = 1'b0;
            end else if (m_gs != 2) begin
                m_act[k] = 1'b0; m_ai[k] = 1'b0;
            end else if (ai[k]) begin
                m_act[k] = 1'b0;
                if (!m_ai[k]) begin
                    m_ai[k] = 1'b1; m_aiage[k] = 0;
                end else begin
                    m_aiage[k]++;
                    if (m_aiage[k] % AD == 0) begin
                        if (int'(ball) > m_pos[k] + DB) m_pos[k] = moved(m_pos[k], 2);
                        else if (int'(ball) < m_pos[k] - DB) m_pos[k] = moved(m_pos[k], 1);
                    end
                end
            end else if (m_ai[k]) begin
                m_ai[k] = 1'b0; m_act[k] = 1'b0;
            end else if (req == 0) begin
                m_act[k] = 1'b0;
            end else if (!m_act[k] || req != m_dir[k]) begin
                m_pos[k] = moved(m_pos[k], req);
                m_dir[k] = req; m_act[k] = 1'b1; m_age[k] = 0;
            end else begin
                m_age[k]++;
                if (m_age[k] == FD || (m_age[k] > FD && (m_age[k] - FD) % RD == 0))
                    m_pos[k] = moved(m_pos[k], m_dir[k]);
            end
        end
        if (rst) m_gs = 0;
        else if (enter) m_gs = 1;
        else if (m_gs == 1 && start) m_gs = 2;
        if (rst) chk = 1'b1;
    end

    task automatic check_val(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check_val("model_game_state", int'(gs), m_gs);
            check_val("model_pos0", int'(vpos[4:0]), m_pos[0]);
            check_val("model_pos1", int'(vpos[9:5]), m_pos[1]);
            check_val("model_draw", int'(draw), int'(m_draw));
            check_val("model_draw_id", int'(id), m_id);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; up = '0; dn = '0; ai = '0; ball = '0;
        ready = 1'b0; start = 1'b0; out = 1'b0; h = '0; v = '0;
        tick(2);
        check_val("rst_state", int'(gs), 0);
        check_val("rst_pos0", int'(vpos[4:0]), 15);
        check_val("rst_pos1", int'(vpos[9:5]), 15);
        check_val("rst_draw", int'(draw), 0);
        rst = 1'b0; ready = 1'b1; tick(1); ready = 1'b0;
        check_val("ready_to_start", int'(gs), 1);
        start = 1'b1; tick(1); start = 1'b0;
        check_val("start_to_play", int'(gs), 2);

        // Hold up on paddle 0: immediate step, first repeat after 4, then every 2.
        up = 2'b01;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            case (i)
                1: check_val("hold_first", int'(vpos[4:0]), 14);
                4: check_val("hold_wait", int'(vpos[4:0]), 14);
                5: check_val("hold_rep1", int'(vpos[4:0]), 13);
                7: check_val("hold_rep2", int'(vpos[4:0]), 12);
                9: check_val("hold_rep3", int'(vpos[4:0]), 11);
                default: ;
            endcase
        end
        up = 2'b00; tick(1);
        check_val("hold_pos1_still", int'(vpos[9:5]), 15);

        out = 1'b1; tick(1); out = 1'b0;
        check_val("out_state", int'(gs), 1);
        check_val("out_reload_pos0", int'(vpos[4:0]), 15);
        up = 2'b01; tick(3); up = 2'b00;
        check_val("start_ignores_btn", int'(vpos[4:0]), 15);

        h = 10'd64; v = 10'd192; tick(1);
        check_val("draw_p0_hit", int'(draw), 1);
        check_val("draw_p0_id", int'(id), 0);
        v = 10'd320; tick(1);
        check_val("draw_p0_below", int'(draw), 0);
        h = 10'd560; v = 10'd200; tick(1);
        check_val("draw_p1_hit", int'(draw), 1);
        check_val("draw_p1_id", int'(id), 1);

        start = 1'b1; tick(1); start = 1'b0;
        dn = 2'b10; tick(30);
        check_val("clamp_max", int'(vpos[9:5]), 26);
        dn = 2'b00; tick(2); dn = 2'b10; tick(5);
        check_val("clamp_repress", int'(vpos[9:5]), 26);
        dn = 2'b00; tick(1);

        // Reversal on paddle 0 restarts the hold sequence.
        up = 2'b01; tick(1);
        check_val("rev_first", int'(vpos[4:0]), 14);
        tick(2);
        check_val("rev_held", int'(vpos[4:0]), 14);
        up = 2'b00; dn = 2'b01; tick(1);
        check_val("rev_step", int'(vpos[4:0]), 15);
        tick(3);
        check_val("rev_wait", int'(vpos[4:0]), 15);
        tick(1);
        check_val("rev_repeat", int'(vpos[4:0]), 16);
        dn = 2'b00; tick(1);

        out = 1'b1; tick(1); out = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        ai = 2'b10; ball = 5'd20;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            case (i)
                3:  check_val("ai_wait", int'(vpos[9:5]), 15);
                4:  check_val("ai_step1", int'(vpos[9:5]), 16);
                7:  check_val("ai_step2", int'(vpos[9:5]), 17);
                10: check_val("ai_step3", int'(vpos[9:5]), 18);
                13: check_val("ai_step4", int'(vpos[9:5]), 19);
                16: check_val("ai_deadband", int'(vpos[9:5]), 19);
                default: ;
            endcase
        end
        ai = 2'b00; tick(2);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 599) == 0);
            ready = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 14) == 0);
            out   = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 7) == 0) up = 2'($urandom);
            if ($urandom_range(0, 7) == 0) dn = 2'($urandom);
            if ($urandom_range(0, 60) == 0) ai = 2'($urandom);
            if ($urandom_range(0, 30) == 0) ball = 5'($urandom_range(0, 29));
            if ($urandom_range(0, 1) == 0)
                h = 10'((($urandom_range(0, 1) == 0) ? 4 : 35) * PS + $urandom_range(0, 15));
            else
                h = 10'($urandom_range(0, 799));
            v = 10'($urandom_range(0, 524));
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
